// File: rtl/core_control_exception_sequencer_pkg.sv
// Shared types and constants for the exception entry sequencer:
// source kinds, FSM states, CPSR mode encodings and vector offsets.
package core_control_exception_sequencer_pkg;

    typedef enum logic [2:0] {
        KIND_NONE,
        KIND_DABT,
        KIND_FIQ,
        KIND_IRQ,
        KIND_PABT,
        KIND_UND,
        KIND_SWI
    } exc_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE_SPSR,
        ST_WRITE_LR,
        ST_SET_MODE,
        ST_FETCH
    } exc_state_e;

    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;

    localparam logic [2:0] VEC_UND  = 3'b001;
    localparam logic [2:0] VEC_SWI  = 3'b010;
    localparam logic [2:0] VEC_PABT = 3'b011;
    localparam logic [2:0] VEC_DABT = 3'b100;
    localparam logic [2:0] VEC_IRQ  = 3'b110;
    localparam logic [2:0] VEC_FIQ  = 3'b111;

    // Pending-bit positions, lowest index = highest priority.
    localparam int NUM_SRC   = 6;
    localparam int PEND_DABT = 0;
    localparam int PEND_FIQ  = 1;
    localparam int PEND_IRQ  = 2;
    localparam int PEND_PABT = 3;
    localparam int PEND_UND  = 4;
    localparam int PEND_SWI  = 5;

    typedef struct packed {
        logic [4:0] mode;
        logic [2:0] offset;
        logic [3:0] lr_adjust;
        logic       set_i;
        logic       set_f;
    } exc_info_t;

endpackage

// File: rtl/core_control_exception_prio.sv
// Priority pick over pending sources, plus the per-kind entry parameters
// (mode, vector offset, LR adjust, mask bits) for the latched kind.
module core_control_exception_prio
    import core_control_exception_sequencer_pkg::*;
(
    input  logic [NUM_SRC-1:0] pend,
    input  exc_kind_e          kind,
    output exc_kind_e          winner,
    output logic [NUM_SRC-1:0] win_bit,
    output exc_info_t          info
);

    always_comb begin
        winner  = KIND_NONE;
        win_bit = '0;
        if (pend[PEND_DABT]) begin
            winner = KIND_DABT;
            win_bit[PEND_DABT] = 1'b1;
        end else if (pend[PEND_FIQ]) begin
            winner = KIND_FIQ;
            win_bit[PEND_FIQ] = 1'b1;
        end else if (pend[PEND_IRQ]) begin
            winner = KIND_IRQ;
            win_bit[PEND_IRQ] = 1'b1;
        end else if (pend[PEND_PABT]) begin
            winner = KIND_PABT;
            win_bit[PEND_PABT] = 1'b1;
        end else if (pend[PEND_UND]) begin
            winner = KIND_UND;
            win_bit[PEND_UND] = 1'b1;
        end else if (pend[PEND_SWI]) begin
            winner = KIND_SWI;
            win_bit[PEND_SWI] = 1'b1;
        end
    end

    always_comb begin
        info = '0;
        case (kind)
            KIND_DABT: info = '{mode: MODE_ABT, offset: VEC_DABT, lr_adjust: 4'd8, set_i: 1'b1, set_f: 1'b0};
            KIND_FIQ:  info = '{mode: MODE_FIQ, offset: VEC_FIQ,  lr_adjust: 4'd4, set_i: 1'b1, set_f: 1'b1};
            KIND_IRQ:  info = '{mode: MODE_IRQ, offset: VEC_IRQ,  lr_adjust: 4'd4, set_i: 1'b1, set_f: 1'b0};
            KIND_PABT: info = '{mode: MODE_ABT, offset: VEC_PABT, lr_adjust: 4'd4, set_i: 1'b1, set_f: 1'b0};
            KIND_UND:  info = '{mode: MODE_UND, offset: VEC_UND,  lr_adjust: 4'd0, set_i: 1'b1, set_f: 1'b0};
            KIND_SWI:  info = '{mode: MODE_SVC, offset: VEC_SWI,  lr_adjust: 4'd0, set_i: 1'b1, set_f: 1'b0};
            default:   info = '0;
        endcase
    end

endmodule

// File: rtl/core_control_exception_sequencer.sv
// Exception entry controller: latches pending sources, picks a winner and
// walks the datapath through SPSR save, LR write, mode update and vector fetch.
module core_control_exception_sequencer
    import core_control_exception_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        issue,
    input  logic        irq,
    input  logic        fiq,
    input  logic        i_mask,
    input  logic        f_mask,
    input  logic        undefined,
    input  logic        swi,
    input  logic        prefetch_abort,
    input  logic        data_abort,
    input  logic        high_vectors,
    input  logic        step_ack,
    output logic        exception,
    output logic        escalating,
    output logic        save_spsr,
    output logic        write_lr,
    output logic        set_mode,
    output logic        fetch_vector,
    output logic [4:0]  exc_mode,
    output logic [3:0]  lr_adjust,
    output logic        set_i,
    output logic        set_f,
    output logic [31:0] exception_vector
);

    exc_state_e         state, state_next;
    exc_kind_e          kind, kind_next, winner;
    logic [NUM_SRC-1:0] pend, pend_next, win_bit;
    exc_info_t          info;

    core_control_exception_prio u_prio (
        .pend    (pend),
        .kind    (kind),
        .winner  (winner),
        .win_bit (win_bit),
        .info    (info)
    );

    // Clear of the accepted winner is applied before new sets, so a fresh
    // pulse on the same edge survives as a new pending instance.
    always_comb begin
        pend_next = pend;
        if (state == ST_IDLE)
            pend_next = pend & ~win_bit;
        if (data_abort)     pend_next[PEND_DABT] = 1'b1;
        if (prefetch_abort) pend_next[PEND_PABT] = 1'b1;
        if (undefined)      pend_next[PEND_UND]  = 1'b1;
        if (swi)            pend_next[PEND_SWI]  = 1'b1;
        if (issue) begin
            pend_next[PEND_IRQ] = irq && !i_mask;
            pend_next[PEND_FIQ] = fiq && !f_mask;
        end
    end

    always_comb begin
        state_next = state;
        kind_next  = kind;
        case (state)
            ST_IDLE: begin
                if (|pend) begin
                    state_next = ST_SAVE_SPSR;
                    kind_next  = winner;
                end
            end
            ST_SAVE_SPSR: if (step_ack) state_next = ST_WRITE_LR;
            ST_WRITE_LR:  if (step_ack) state_next = ST_SET_MODE;
            ST_SET_MODE:  if (step_ack) state_next = ST_FETCH;
            ST_FETCH:     if (step_ack) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            kind  <= KIND_NONE;
            pend  <= '0;
        end else begin
            state <= state_next;
            kind  <= kind_next;
            pend  <= pend_next;
        end
    end

    assign escalating   = (state != ST_IDLE);
    assign exception    = (|pend) || escalating;
    assign save_spsr    = (state == ST_SAVE_SPSR);
    assign write_lr     = (state == ST_WRITE_LR);
    assign set_mode     = (state == ST_SET_MODE);
    assign fetch_vector = (state == ST_FETCH);

    assign exc_mode         = info.mode;
    assign lr_adjust        = info.lr_adjust;
    assign set_i            = info.set_i;
    assign set_f            = info.set_f;
    assign exception_vector = {{16{high_vectors}}, 11'b0, info.offset, 2'b00};

endmodule

// File: tb/tb_core_control_exception_sequencer.sv
// Directed bench for the exception entry sequencer: a vector table for the
// basic entry/priority/masking cases plus hand-built stall, same-edge and reset sequences.
module tb_core_control_exception_sequencer;

    logic        clk, rst;
    logic        issue, irq, fiq, i_mask, f_mask;
    logic        undefined, swi, prefetch_abort, data_abort;
    logic        high_vectors, step_ack;
    logic        exception, escalating;
    logic        save_spsr, write_lr, set_mode, fetch_vector;
    logic [4:0]  exc_mode;
    logic [3:0]  lr_adjust;
    logic        set_i, set_f;
    logic [31:0] exception_vector;

    int checks = 0;
    int errors = 0;

    core_control_exception_sequencer dut (
        .clk(clk), .rst(rst), .issue(issue), .irq(irq), .fiq(fiq),
        .i_mask(i_mask), .f_mask(f_mask), .undefined(undefined), .swi(swi),
        .prefetch_abort(prefetch_abort), .data_abort(data_abort),
        .high_vectors(high_vectors), .step_ack(step_ack),
        .exception(exception), .escalating(escalating),
        .save_spsr(save_spsr), .write_lr(write_lr), .set_mode(set_mode),
        .fetch_vector(fetch_vector), .exc_mode(exc_mode), .lr_adjust(lr_adjust),
        .set_i(set_i), .set_f(set_f), .exception_vector(exception_vector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input bit positions: {issue,irq,fiq,i_mask,f_mask,und,swi,pabt,dabt,hv,ack}
    localparam logic [10:0] ISSUE = 11'h400, IRQ = 11'h200, FIQ = 11'h100, IMSK = 11'h080;
    localparam logic [10:0] FMSK = 11'h040, UND = 11'h020, SWI = 11'h010, PABT = 11'h008;
    localparam logic [10:0] DABT = 11'h004, HV = 11'h002, ACK = 11'h001, NONE = 11'h000;
    localparam logic [3:0] S_NONE = 4'b0000;

    typedef struct {
        logic [10:0] in;
        logic [3:0]  strb;
        logic        exc;
        logic        esc;
        logic        cd;
        logic [4:0]  mode;
        logic [3:0]  lr;
        logic        si;
        logic        sf;
        logic [31:0] vec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [10:0] in, input logic [3:0] strb, input logic exc,
                                input logic esc, input logic cd, input logic [4:0] mode,
                                input logic [3:0] lr, input logic si, input logic sf,
                                input logic [31:0] vec);
        vec_t v;
        v.in = in; v.strb = strb; v.exc = exc; v.esc = esc; v.cd = cd;
        v.mode = mode; v.lr = lr; v.si = si; v.sf = sf; v.vec = vec;
        return v;
    endfunction

    function automatic logic [3:0] step_strb(input int s);
        logic [3:0] r;
        r = 4'b1000 >> s;
        return r;
    endfunction

    task automatic drive(input logic [10:0] in);
        {issue, irq, fiq, i_mask, f_mask, undefined, swi, prefetch_abort,
         data_abort, high_vectors, step_ack} = in;
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all(input vec_t v, input string nm);
        cmp({nm, ".strobes"}, {28'd0, save_spsr, write_lr, set_mode, fetch_vector}, {28'd0, v.strb});
        cmp({nm, ".exception"}, {31'd0, exception}, {31'd0, v.exc});
        cmp({nm, ".escalating"}, {31'd0, escalating}, {31'd0, v.esc});
        if (v.cd) begin
            cmp({nm, ".exc_mode"}, {27'd0, exc_mode}, {27'd0, v.mode});
            cmp({nm, ".lr_adjust"}, {28'd0, lr_adjust}, {28'd0, v.lr});
            cmp({nm, ".set_if"}, {30'd0, set_i, set_f}, {30'd0, v.si, v.sf});
            cmp({nm, ".vector"}, exception_vector, v.vec);
        end
    endtask

    // Entered at posedge+1: drive, sample mid-cycle, advance to next posedge+1.
    task automatic apply(input vec_t v, input string nm);
        drive(v.in);
        #3;
        cmp_all(v, nm);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(NONE);
        #2;
        cmp_all(mk(NONE, S_NONE, 0, 0, 1, 5'd0, 4'd0, 0, 0, 32'h0), "in_reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Undefined entry, low vectors, ack tied high
        tbl.push_back(mk(UND | ACK, S_NONE, 0, 0, 1, 5'd0, 4'd0, 0, 0, 32'h0));
        tbl.push_back(mk(ACK, S_NONE, 1, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0));
        for (int s = 0; s < 4; s++)
            tbl.push_back(mk(ACK, step_strb(s), 1, 1, 1, 5'b11011, 4'd0, 1, 0, 32'h0000_0004));
        tbl.push_back(mk(ACK, S_NONE, 0, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0));
        // Data abort beats IRQ, high vectors; IRQ follows
        tbl.push_back(mk(DABT | ISSUE | IRQ | HV | ACK, S_NONE, 0, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0));
        tbl.push_back(mk(HV | ACK, S_NONE, 1, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0));
        for (int s = 0; s < 4; s++)
            tbl.push_back(mk(HV | ACK, step_strb(s), 1, 1, 1, 5'b10111, 4'd8, 1, 0, 32'hFFFF_0010));
        tbl.push_back(mk(HV | ACK, S_NONE, 1, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0));
        for (int s = 0; s < 4; s++)
            tbl.push_back(mk(HV | ACK, step_strb(s), 1, 1, 1, 5'b10010, 4'd4, 1, 0, 32'hFFFF_0018));
        tbl.push_back(mk(HV | ACK, S_NONE, 0, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0));
        // Masked IRQ stays out; unmasked issue takes it
        tbl.push_back(mk(ISSUE | IRQ | IMSK | ACK, S_NONE, 0, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0));
        tbl.push_back(mk(IRQ | IMSK | ACK, S_NONE, 0, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0));
        tbl.push_back(mk(ISSUE | IRQ | ACK, S_NONE, 0, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0));
        tbl.push_back(mk(ACK, S_NONE, 1, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0));
        for (int s = 0; s < 4; s++)
            tbl.push_back(mk(ACK, step_strb(s), 1, 1, 1, 5'b10010, 4'd4, 1, 0, 32'h0000_0018));
        tbl.push_back(mk(ACK, S_NONE, 0, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // FIQ raised during a stalled IRQ sequence
        apply(mk(ISSUE | IRQ, S_NONE, 0, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0), "stall.arm");
        apply(mk(NONE, S_NONE, 1, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0), "stall.pend");
        for (int s = 0; s < 4; s++)
            for (int j = 0; j < 4; j++)
                apply(mk(((j == 3) ? ACK : NONE) | ((s == 0 && j == 0) ? (ISSUE | FIQ) : NONE),
                         step_strb(s), 1, 1, 1, 5'b10010, 4'd4, 1, 0, 32'h0000_0018),
                      $sformatf("stall.irq%0d_%0d", s, j));
        apply(mk(NONE, S_NONE, 1, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0), "stall.idle");
        for (int s = 0; s < 4; s++)
            apply(mk(ACK, step_strb(s), 1, 1, 1, 5'b10001, 4'd4, 1, 1, 32'h0000_001C),
                  $sformatf("stall.fiq%0d", s));
        apply(mk(ACK, S_NONE, 0, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0), "stall.done");

        // SWI re-pulsed on the edge its first instance is accepted
        apply(mk(SWI | ACK, S_NONE, 0, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0), "swi.p1");
        apply(mk(SWI | ACK, S_NONE, 1, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0), "swi.p2");
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 4; s++)
                apply(mk(ACK, step_strb(s), 1, 1, 1, 5'b10011, 4'd0, 1, 0, 32'h0000_0008),
                      $sformatf("swi.run%0d_%0d", r, s));
            apply(mk(ACK, S_NONE, (r == 0) ? 1'b1 : 1'b0, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0),
                  $sformatf("swi.idle%0d", r));
        end

        // Reset in WRITE_LR with another source pending
        apply(mk(PABT | HV | ACK, S_NONE, 0, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0), "rst.arm");
        apply(mk(HV | ACK, S_NONE, 1, 0, 0, 5'd0, 4'd0, 0, 0, 32'h0), "rst.pend");
        apply(mk(HV | ACK, 4'b1000, 1, 1, 1, 5'b10111, 4'd4, 1, 0, 32'hFFFF_000C), "rst.save");
        apply(mk(HV | UND, 4'b0100, 1, 1, 1, 5'b10111, 4'd4, 1, 0, 32'hFFFF_000C), "rst.lr");
        drive(HV | ACK);
        #1;
        cmp_all(mk(HV | ACK, 4'b0100, 1, 1, 0, 5'd0, 4'd0, 0, 0, 32'h0), "rst.before");
        rst = 1'b1;
        #1;
        cmp_all(mk(HV | ACK, S_NONE, 0, 0, 1, 5'd0, 4'd0, 0, 0, 32'hFFFF_0000), "rst.async");
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++)
            apply(mk(HV | ACK, S_NONE, 0, 0, 1, 5'd0, 4'd0, 0, 0, 32'hFFFF_0000),
                  $sformatf("rst.after%0d", c));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
